// File: rtl/ee357_rr_mux_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin mux arbiter.
package ee357_rr_mux_arbiter_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   // 2'd3 is unused; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/ee357_rr_pick.sv
// Combinational round-robin picker: first set req bit searching ptr, ptr+1, ... mod NREQ.
module ee357_rr_pick
   import ee357_rr_mux_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = ptr;
      // Index arithmetic is 2-bit so ptr+k wraps 3->0 naturally.
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[ptr + SEL_W'(k)]) begin
            found = 1'b1;
            idx   = ptr + SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/ee357_rr_mux_arbiter.sv
// Round-robin arbiter owning the select of the shared 4x32 mux; one-hot registered grant,
// hold-until-release ownership and a one-cycle turnaround between owners.
module ee357_rr_mux_arbiter
   import ee357_rr_mux_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic [NREQ-1:0]  grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic [7:0]       hold_cnt;
   logic             found;
   logic [SEL_W-1:0] idx;
   logic             timeout;
   logic             release_own;

   ee357_rr_pick u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (found),
      .idx   (idx)
   );

   // While in OWN, sel always holds the owner's index.
   assign timeout     = (MAX_HOLD != 0) && (hold_cnt == 8'(MAX_HOLD - 1));
   assign release_own = done || !req[sel] || timeout;
   assign dbg_state   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         grant    <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_GAP: begin
               if (found) begin
                  grant    <= NREQ'(1) << idx;
                  sel      <= idx;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= ST_OWN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_OWN: begin
               // sel stays on the old owner through the gap so the mux never switches mid-transfer.
               if (release_own) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  ptr   <= sel + SEL_W'(1);
                  state <= ST_GAP;
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
